// File: rtl/ervp_app_load_pkg.sv
// Shared definitions for the app-load sequencer: boot modes, FSM encoding
// and the byte-swap helper used on the write data path.
package ervp_app_load_pkg;

    localparam int BW_BOOT_MODE = 2;
    localparam logic [BW_BOOT_MODE-1:0] BOOT_MODE_STAND_ALONE = 2'd0;
    localparam logic [BW_BOOT_MODE-1:0] BOOT_MODE_OCD         = 2'd1;

    // Widest data word the byte-swap helper can handle.
    localparam int MAX_BW_DATA = 256;

    typedef enum logic [2:0] {
        ST_SETTLE  = 3'd0,
        ST_CHECK   = 3'd1,
        ST_RELEASE = 3'd2,
        ST_LOAD    = 3'd3,
        ST_DRAIN   = 3'd4,
        ST_SETENV  = 3'd5,
        ST_DONE    = 3'd6,
        ST_ERROR   = 3'd7
    } state_t;

    // Reverse the byte order of the low num_bytes bytes of word; upper bytes
    // of the result are zero.
    function automatic logic [MAX_BW_DATA-1:0] byte_swap(
        input logic [MAX_BW_DATA-1:0] word,
        input int                     num_bytes
    );
        logic [MAX_BW_DATA-1:0] swapped;
        swapped = '0;
        for (int i = 0; i < MAX_BW_DATA / 8; i++) begin
            if (i < num_bytes) begin
                swapped[i*8 +: 8] = word[(num_bytes-1-i)*8 +: 8];
            end
        end
        return swapped;
    endfunction

endpackage

// File: rtl/ervp_app_load_skid.sv
// One-entry valid/ready buffer between the word source and the memory write
// port. Captures (optionally byte-swapped) data together with its address.
module ervp_app_load_skid
    import ervp_app_load_pkg::*;
#(
    parameter int BW_ADDR     = 32,
    parameter int BW_DATA     = 32,
    parameter int SWAP_ENDIAN = 0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               enable,
    input  logic               in_valid,
    input  logic [BW_DATA-1:0] in_data,
    input  logic [BW_ADDR-1:0] in_addr,
    output logic               in_ready,
    output logic               out_valid,
    output logic [BW_ADDR-1:0] out_addr,
    output logic [BW_DATA-1:0] out_data,
    input  logic               out_ready
);

    logic               buf_valid_reg;
    logic [BW_ADDR-1:0] buf_addr_reg;
    logic [BW_DATA-1:0] buf_data_reg;
    logic [BW_DATA-1:0] load_data;
    logic               in_fire;
    logic               out_fire;

    generate
        if (SWAP_ENDIAN != 0) begin : g_swap
            assign load_data = BW_DATA'(byte_swap(MAX_BW_DATA'(in_data), BW_DATA / 8));
        end else begin : g_noswap
            assign load_data = in_data;
        end
    endgenerate

    // A full buffer can still take a word in the cycle it is being drained.
    assign in_ready  = enable && (!buf_valid_reg || out_ready);
    assign in_fire   = in_valid && in_ready;
    assign out_fire  = buf_valid_reg && out_ready;

    assign out_valid = buf_valid_reg;
    assign out_addr  = buf_addr_reg;
    assign out_data  = buf_data_reg;

    // Buffer fill/drain; a refill wins over a drain in the same cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            buf_valid_reg <= 1'b0;
            buf_addr_reg  <= '0;
            buf_data_reg  <= '0;
        end else if (in_fire) begin
            buf_valid_reg <= 1'b1;
            buf_addr_reg  <= in_addr;
            buf_data_reg  <= load_data;
        end else if (out_fire) begin
            buf_valid_reg <= 1'b0;
        end
    end

endmodule

// File: rtl/ervp_app_load_sequencer.sv
// Boot/app-load sequencer: waits a settle period after reset, then either
// releases the subsystem directly (stand-alone) or streams source words into
// a list of memory regions (OCD) before flagging the application ready.
module ervp_app_load_sequencer
    import ervp_app_load_pkg::*;
#(
    parameter int NUM_REGION    = 2,
    parameter int BW_ADDR       = 32,
    parameter int BW_DATA       = 32,
    parameter int BW_COUNT      = 20,
    parameter int SETTLE_CYCLES = 300,
    parameter int SWAP_ENDIAN   = 0,
    parameter int PROGRESS_MASK = 255,
    localparam int BW_REGION    = (NUM_REGION > 1) ? $clog2(NUM_REGION) : 1
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [BW_BOOT_MODE-1:0]        boot_mode,
    input  logic [NUM_REGION*BW_ADDR-1:0]  region_base_list,
    input  logic [NUM_REGION*BW_COUNT-1:0] region_size_list,
    input  logic                           src_valid,
    input  logic [BW_DATA-1:0]             src_data,
    output logic                           src_ready,
    output logic                           mem_wvalid,
    output logic [BW_ADDR-1:0]             mem_waddr,
    output logic [BW_DATA-1:0]             mem_wdata,
    input  logic                           mem_wready,
    output logic                           subsys_release,
    output logic                           app_ready,
    output logic                           busy,
    output logic                           error,
    output logic [BW_REGION-1:0]           region_index,
    output logic                           progress_pulse
);

    localparam int BW_SETTLE = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [BW_SETTLE-1:0] SETTLE_LAST =
        BW_SETTLE'((SETTLE_CYCLES > 0) ? SETTLE_CYCLES - 1 : 0);
    localparam logic [BW_ADDR-1:0]  ADDR_STEP = BW_ADDR'(BW_DATA / 8);
    localparam logic [BW_COUNT-1:0] PMASK     = BW_COUNT'(PROGRESS_MASK);

    state_t                         state_reg;
    state_t                         state_next;
    logic [BW_SETTLE-1:0]           settle_count_reg;
    logic [NUM_REGION*BW_ADDR-1:0]  base_list_reg;
    logic [NUM_REGION*BW_COUNT-1:0] size_list_reg;
    logic [BW_ADDR-1:0]             base_arr [NUM_REGION];
    logic [BW_COUNT-1:0]            size_arr [NUM_REGION];
    logic [BW_REGION-1:0]           region_index_reg;
    logic [BW_ADDR-1:0]             addr_reg;
    logic [BW_COUNT-1:0]            word_count_reg;

    logic                           first_found;
    logic [BW_REGION-1:0]           first_idx;
    logic                           next_found;
    logic [BW_REGION-1:0]           next_idx;
    logic                           load_active;
    logic                           src_accept;
    logic                           last_word;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REGION; gi++) begin : g_region
            assign base_arr[gi] = base_list_reg[gi*BW_ADDR +: BW_ADDR];
            assign size_arr[gi] = size_list_reg[gi*BW_COUNT +: BW_COUNT];
        end
    endgenerate

    // Lowest non-empty region overall, and lowest non-empty one after the current.
    always_comb begin
        first_found = 1'b0;
        first_idx   = '0;
        next_found  = 1'b0;
        next_idx    = '0;
        for (int i = NUM_REGION - 1; i >= 0; i--) begin
            if (size_arr[i] != '0) begin
                first_found = 1'b1;
                first_idx   = BW_REGION'(i);
                if (i > int'(region_index_reg)) begin
                    next_found = 1'b1;
                    next_idx   = BW_REGION'(i);
                end
            end
        end
    end

    assign src_accept     = src_valid && src_ready;
    assign last_word      = (word_count_reg == size_arr[region_index_reg] - BW_COUNT'(1));
    assign progress_pulse = src_accept && ((word_count_reg & PMASK) == PMASK);
    assign region_index   = region_index_reg;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= ST_SETTLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_SETTLE: begin
                if (settle_count_reg == SETTLE_LAST) state_next = ST_CHECK;
            end
            ST_CHECK: begin
                if (boot_mode == BOOT_MODE_STAND_ALONE)  state_next = ST_DONE;
                else if (boot_mode == BOOT_MODE_OCD)     state_next = ST_RELEASE;
                else                                     state_next = ST_ERROR;
            end
            ST_RELEASE: state_next = first_found ? ST_LOAD : ST_SETENV;
            ST_LOAD: begin
                if (src_accept && last_word && !next_found) state_next = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (!mem_wvalid) state_next = ST_SETENV;
            end
            ST_SETENV: state_next = ST_DONE;
            ST_DONE:   state_next = ST_DONE;
            ST_ERROR:  state_next = ST_ERROR;
            default:   state_next = ST_SETTLE;
        endcase
    end

    // Moore outputs decoded from the state.
    always_comb begin
        subsys_release = 1'b0;
        app_ready      = 1'b0;
        busy           = 1'b0;
        error          = 1'b0;
        load_active    = 1'b0;
        case (state_reg)
            ST_RELEASE: subsys_release = 1'b1;
            ST_LOAD: begin
                subsys_release = 1'b1;
                busy           = 1'b1;
                load_active    = 1'b1;
            end
            ST_DRAIN: begin
                subsys_release = 1'b1;
                busy           = 1'b1;
            end
            ST_SETENV:  subsys_release = 1'b1;
            ST_DONE: begin
                subsys_release = 1'b1;
                app_ready      = 1'b1;
            end
            ST_ERROR:   error = 1'b1;
            default: ;
        endcase
    end

    // Settle counter, configuration snapshot, region/address/word tracking.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            settle_count_reg <= '0;
            base_list_reg    <= '0;
            size_list_reg    <= '0;
            region_index_reg <= '0;
            addr_reg         <= '0;
            word_count_reg   <= '0;
        end else begin
            if (state_reg == ST_SETTLE && settle_count_reg != SETTLE_LAST) begin
                settle_count_reg <= settle_count_reg + BW_SETTLE'(1);
            end
            if (state_reg == ST_CHECK) begin
                base_list_reg <= region_base_list;
                size_list_reg <= region_size_list;
            end
            if (state_reg == ST_RELEASE) begin
                // Empty leading regions are skipped without spending a cycle.
                region_index_reg <= first_idx;
                addr_reg         <= base_arr[first_idx];
                word_count_reg   <= '0;
            end
            if (state_reg == ST_LOAD && src_accept) begin
                if (last_word) begin
                    word_count_reg <= '0;
                    if (next_found) begin
                        region_index_reg <= next_idx;
                        addr_reg         <= base_arr[next_idx];
                    end
                end else begin
                    word_count_reg <= word_count_reg + BW_COUNT'(1);
                    addr_reg       <= addr_reg + ADDR_STEP;
                end
            end
        end
    end

    ervp_app_load_skid #(
        .BW_ADDR     (BW_ADDR),
        .BW_DATA     (BW_DATA),
        .SWAP_ENDIAN (SWAP_ENDIAN)
    ) u_skid (
        .clk       (clk),
        .rst       (rst),
        .enable    (load_active),
        .in_valid  (src_valid),
        .in_data   (src_data),
        .in_addr   (addr_reg),
        .in_ready  (src_ready),
        .out_valid (mem_wvalid),
        .out_addr  (mem_waddr),
        .out_data  (mem_wdata),
        .out_ready (mem_wready)
    );

endmodule

// File: tb/tb_ervp_app_load_sequencer.sv
// Directed bench for ervp_app_load_sequencer. Two instances run in lockstep on
// the same stimulus: one without and one with byte swapping.
module tb_ervp_app_load_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  boot_mode = 2'd0;
    logic [63:0] region_base_list = '0;
    logic [39:0] region_size_list = '0;
    logic        src_valid = 1'b0;
    logic [31:0] src_data = '0;
    logic        mem_wready = 1'b1;

    logic        src_ready, mem_wvalid, subsys_release, app_ready, busy, error;
    logic        progress_pulse, region_index;
    logic [31:0] mem_waddr, mem_wdata;

    logic        s_src_ready, s_mem_wvalid, s_subsys_release, s_app_ready, s_busy, s_error;
    logic        s_progress_pulse, s_region_index;
    logic [31:0] s_mem_waddr, s_mem_wdata;

    always #5 clk = ~clk;

    ervp_app_load_sequencer dut (
        .clk(clk), .rst(rst), .boot_mode(boot_mode),
        .region_base_list(region_base_list), .region_size_list(region_size_list),
        .src_valid(src_valid), .src_data(src_data), .src_ready(src_ready),
        .mem_wvalid(mem_wvalid), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata),
        .mem_wready(mem_wready), .subsys_release(subsys_release), .app_ready(app_ready),
        .busy(busy), .error(error), .region_index(region_index),
        .progress_pulse(progress_pulse)
    );

    ervp_app_load_sequencer #(.SWAP_ENDIAN(1)) dut_swap (
        .clk(clk), .rst(rst), .boot_mode(boot_mode),
        .region_base_list(region_base_list), .region_size_list(region_size_list),
        .src_valid(src_valid), .src_data(src_data), .src_ready(s_src_ready),
        .mem_wvalid(s_mem_wvalid), .mem_waddr(s_mem_waddr), .mem_wdata(s_mem_wdata),
        .mem_wready(mem_wready), .subsys_release(s_subsys_release), .app_ready(s_app_ready),
        .busy(s_busy), .error(s_error), .region_index(s_region_index),
        .progress_pulse(s_progress_pulse)
    );

    typedef struct {
        logic [31:0] data;
        logic [31:0] exp_addr;
        logic [31:0] exp_swap;
    } vec_t;

    vec_t        vt [7];
    logic [31:0] src_mem [1024];
    logic [31:0] wr_addr [$];
    logic [31:0] wr_data [$];
    logic [31:0] wr_sdata [$];
    int          pulse_idx [$];
    int          first_ri;
    int          checks = 0;
    int          errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    task automatic clear_log();
        wr_addr.delete();
        wr_data.delete();
        wr_sdata.delete();
        pulse_idx.delete();
        first_ri = -1;
    endtask

    task automatic do_reset(input logic [1:0] mode, input logic [63:0] bases,
                            input logic [39:0] sizes);
        @(negedge clk);
        rst = 1'b1;
        boot_mode = mode;
        region_base_list = bases;
        region_size_list = sizes;
        src_valid = 1'b0;
        mem_wready = 1'b1;
        clear_log();
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    // Drive src_mem[0..n_src-1] and log memory writes until app_ready,
    // stop_acc accepted words (if > 0) or the cycle budget runs out.
    // bp != 0 toggles mem_wready every cycle and checks stall behaviour.
    task automatic run_stream(input int n_src, input int bp, input int stop_acc,
                              input int budget);
        int          idx = 0;
        int          cyc = 0;
        logic        done = 1'b0;
        logic        acc;
        logic        prev_stall = 1'b0;
        logic [31:0] pa = '0;
        logic [31:0] pd = '0;
        while (!done && cyc < budget) begin
            @(negedge clk);
            src_valid  = (idx < n_src);
            src_data   = src_mem[idx % 1024];
            mem_wready = (bp == 0) ? 1'b1 : ((cyc % 2) == 1);
            #1;
            if (prev_stall) begin
                chk("bp_wvalid_held", 32'(mem_wvalid), 32'd1);
                chk("bp_waddr_held", mem_waddr, pa);
                chk("bp_wdata_held", mem_wdata, pd);
            end
            if (mem_wvalid && !mem_wready) chk("stall_src_ready_low", 32'(src_ready), 32'd0);
            if (busy && first_ri < 0) first_ri = int'(region_index);
            if (progress_pulse) pulse_idx.push_back(idx);
            if (mem_wvalid && mem_wready) begin
                wr_addr.push_back(mem_waddr);
                wr_data.push_back(mem_wdata);
                wr_sdata.push_back(s_mem_wdata);
            end
            prev_stall = mem_wvalid && !mem_wready;
            pa = mem_waddr;
            pd = mem_wdata;
            acc = src_valid && src_ready;
            if (app_ready) begin
                done = 1'b1;
            end else begin
                @(posedge clk);
                if (acc) idx++;
                cyc++;
                if (stop_acc > 0 && idx >= stop_acc) done = 1'b1;
            end
        end
        src_valid = 1'b0;
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL stream_timeout actual=%0d cycles required=done", cyc);
        end
    endtask

    task automatic check_table(input string tag);
        chk({tag, "_write_count"}, 32'(wr_addr.size()), 32'd7);
        for (int i = 0; i < 7; i++) begin
            if (i < wr_addr.size()) begin
                $display("%s write %0d addr=0x%08h data=0x%08h swapped=0x%08h",
                         tag, i, wr_addr[i], wr_data[i], wr_sdata[i]);
                chk({tag, "_addr"}, wr_addr[i], vt[i].exp_addr);
                chk({tag, "_data"}, wr_data[i], vt[i].data);
                chk({tag, "_swap_data"}, wr_sdata[i], vt[i].exp_swap);
            end
        end
    endtask

    initial begin
        logic saw_wvalid;

        vt[0] = '{32'h0000_0001, 32'h0000_0000, 32'h0100_0000};
        vt[1] = '{32'h0000_0002, 32'h0000_0004, 32'h0200_0000};
        vt[2] = '{32'h0000_0003, 32'h0000_0008, 32'h0300_0000};
        vt[3] = '{32'h0000_0004, 32'h0000_000C, 32'h0400_0000};
        vt[4] = '{32'h0000_0005, 32'h8000_0000, 32'h0500_0000};
        vt[5] = '{32'hA5B6_C7D8, 32'h8000_0004, 32'hD8C7_B6A5};
        vt[6] = '{32'h1234_5678, 32'h8000_0008, 32'h7856_3412};
        clear_log();

        // Reset state
        #1;
        chk("reset_flags", 32'({src_ready, mem_wvalid, subsys_release, app_ready,
                                busy, error, region_index, progress_pulse}), 32'd0);
        chk("reset_waddr", mem_waddr, 32'd0);
        chk("reset_wdata", mem_wdata, 32'd0);

        // Stand-alone boot: release and app_ready exactly 301 cycles after reset
        do_reset(2'd0, 64'd0, 40'd0);
        saw_wvalid = 1'b0;
        repeat (300) begin
            @(posedge clk); #1;
            if (mem_wvalid) saw_wvalid = 1'b1;
        end
        chk("sa_app_ready_at_300", 32'(app_ready), 32'd0);
        chk("sa_release_at_300", 32'(subsys_release), 32'd0);
        @(posedge clk); #1;
        chk("sa_app_ready_at_301", 32'(app_ready), 32'd1);
        chk("sa_release_at_301", 32'(subsys_release), 32'd1);
        chk("sa_busy", 32'(busy), 32'd0);
        repeat (5) begin
            @(posedge clk); #1;
            if (mem_wvalid) saw_wvalid = 1'b1;
        end
        chk("sa_no_wvalid", 32'(saw_wvalid), 32'd0);
        chk("sa_app_ready_held", 32'(app_ready), 32'd1);

        // OCD load of two regions, no backpressure
        for (int i = 0; i < 7; i++) src_mem[i] = vt[i].data;
        do_reset(2'd1, {32'h8000_0000, 32'h0000_0000}, {20'd3, 20'd4});
        run_stream(7, 0, 0, 2000);
        check_table("ocd");
        chk("ocd_app_ready", 32'(app_ready), 32'd1);
        chk("ocd_swap_app_ready", 32'(s_app_ready), 32'd1);
        chk("ocd_first_region", 32'(first_ri), 32'd0);
        chk("ocd_no_progress", 32'(pulse_idx.size()), 32'd0);
        @(negedge clk);
        chk("ocd_done_busy", 32'(busy), 32'd0);
        chk("ocd_done_release", 32'(subsys_release), 32'd1);

        // Same load with mem_wready toggling every cycle
        do_reset(2'd1, {32'h8000_0000, 32'h0000_0000}, {20'd3, 20'd4});
        run_stream(7, 1, 0, 2000);
        check_table("bp");
        chk("bp_app_ready", 32'(app_ready), 32'd1);

        // Region 0 empty: loading starts directly at region 1
        do_reset(2'd1, {32'h0000_0100, 32'h0000_0000}, {20'd3, 20'd0});
        run_stream(3, 0, 0, 2000);
        chk("skip_first_region", 32'(first_ri), 32'd1);
        chk("skip_write_count", 32'(wr_addr.size()), 32'd3);
        if (wr_addr.size() == 3) begin
            chk("skip_addr0", wr_addr[0], 32'h0000_0100);
            chk("skip_addr2", wr_addr[2], 32'h0000_0108);
            chk("skip_data2", wr_data[2], 32'h0000_0003);
        end

        // All regions empty: straight to done with no writes
        do_reset(2'd1, 64'd0, 40'd0);
        run_stream(0, 0, 0, 2000);
        chk("empty_write_count", 32'(wr_addr.size()), 32'd0);
        chk("empty_app_ready", 32'(app_ready), 32'd1);

        // Address wraps past the top of the address space
        do_reset(2'd1, {32'h0000_0000, 32'hFFFF_FFFC}, {20'd0, 20'd2});
        run_stream(2, 0, 0, 2000);
        chk("wrap_write_count", 32'(wr_addr.size()), 32'd2);
        if (wr_addr.size() == 2) begin
            chk("wrap_addr0", wr_addr[0], 32'hFFFF_FFFC);
            chk("wrap_addr1", wr_addr[1], 32'h0000_0000);
        end

        // Progress pulses on a 512-word region
        for (int i = 0; i < 512; i++) src_mem[i] = 32'(i) + 32'h100;
        do_reset(2'd1, {32'h0000_0000, 32'h0000_1000}, {20'd0, 20'd512});
        run_stream(512, 0, 0, 3000);
        chk("prog_pulse_count", 32'(pulse_idx.size()), 32'd2);
        if (pulse_idx.size() == 2) begin
            chk("prog_pulse_word_a", 32'(pulse_idx[0] + 1), 32'd256);
            chk("prog_pulse_word_b", 32'(pulse_idx[1] + 1), 32'd512);
        end
        chk("prog_write_count", 32'(wr_addr.size()), 32'd512);
        if (wr_addr.size() == 512) begin
            chk("prog_last_addr", wr_addr[511], 32'h0000_17FC);
            chk("prog_last_data", wr_data[511], 32'h0000_02FF);
        end

        // Illegal boot mode is sticky until reset
        do_reset(2'd3, 64'd0, 40'd0);
        repeat (301) @(posedge clk);
        #1;
        chk("err_error", 32'(error), 32'd1);
        chk("err_release", 32'(subsys_release), 32'd0);
        chk("err_app_ready", 32'(app_ready), 32'd0);
        repeat (20) @(posedge clk);
        #1;
        chk("err_sticky", 32'(error), 32'd1);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("err_cleared_by_rst", 32'(error), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        chk("err_stays_clear", 32'(error), 32'd0);

        // Reset in the middle of a load restarts the whole sequence
        for (int i = 0; i < 7; i++) src_mem[i] = vt[i].data;
        do_reset(2'd1, {32'h8000_0000, 32'h0000_0000}, {20'd3, 20'd4});
        run_stream(7, 0, 2, 2000);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("midrst_flags", 32'({src_ready, mem_wvalid, subsys_release, app_ready,
                                 busy, error, region_index, progress_pulse}), 32'd0);
        chk("midrst_waddr", mem_waddr, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        clear_log();
        repeat (150) @(posedge clk);
        #1;
        chk("midrst_in_settle", 32'({subsys_release, busy}), 32'd0);
        run_stream(7, 0, 0, 2000);
        check_table("restart");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ervp_app_load_sequencer.md
Name: ervp_app_load_sequencer

Overview:
Synthesizable boot/app-load sequencer that replaces the testbench-only OCD load flow with a hardware block usable on-chip or in sim.
- After reset it waits a settle period, then releases subsystem reset.
- In OCD mode it streams words from a source (JTAG/UART bridge) into NUM_REGION memory regions with optional byte-swap, then asserts app_ready.
- Sits between the debug/loader front-end and the platform memory write port.

Parameters:
NUM_REGION, 2, number of memory regions loaded in order (e.g. SRAM, DRAM)
BW_ADDR, 32, memory address width
BW_DATA, 32, word width; multiple of 8
BW_COUNT, 20, per-region word-count width
SETTLE_CYCLES, 300, clk cycles waited after reset before any action
SWAP_ENDIAN, 0, 1 = byte-reverse each word before writing
PROGRESS_MASK, 255, progress_pulse fires when (word_count & PROGRESS_MASK) == PROGRESS_MASK

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
boot_mode  in  2  0 = stand-alone, 1 = OCD, others illegal; sampled at end of settle
region_base_list  in  NUM_REGION*BW_ADDR  byte base address per region; region i in bits [i*BW_ADDR +: BW_ADDR]
region_size_list  in  NUM_REGION*BW_COUNT  words per region; 0 = skip region
src_valid  in  1  source word valid
src_data  in  BW_DATA  source word
src_ready  out  1  source word accepted when valid & ready
mem_wvalid  out  1  memory write request
mem_waddr  out  BW_ADDR  write byte address
mem_wdata  out  BW_DATA  write data (endian-adjusted)
mem_wready  in  1  memory accepts when wvalid & wready
subsys_release  out  1  subsystem reset release (1 = released)
app_ready  out  1  load complete, application may run
busy  out  1  loading in progress
error  out  1  sticky illegal boot_mode
region_index  out  log2(NUM_REGION), min 1  region currently loading
progress_pulse  out  1  one-cycle pulse per progress boundary

Behaviour:
- Reset values: all outputs 0, state SETTLE, counters 0, skid buffer empty. rst mid-operation aborts everything and restarts from SETTLE; partial writes are not undone.
- Reset release must not depend on memory handshakes.
- FSM states: SETTLE, CHECK, RELEASE, LOAD, DRAIN, SETENV, DONE, ERROR.
- SETTLE: count cycles. At count == SETTLE_CYCLES-1, go to CHECK.
- CHECK: one cycle; samples boot_mode, region_base_list and region_size_list into registers.
  - boot_mode 0: go to DONE; subsys_release=1 and app_ready=1 set the same cycle.
  - boot_mode 1: go to RELEASE.
  - Otherwise: go to ERROR (error=1, absorbing until rst; app_ready stays 0).
- RELEASE: subsys_release=1 from this cycle onward. Go to LOAD at region 0 with address = base[0].
  - Regions with size 0 are skipped with no cycle spent on them.
  - If all regions are size 0, go straight to SETENV.
- LOAD: busy=1. Single-entry skid buffer.
  - src_ready = !buf_valid | mem_wready, and is 0 outside LOAD.
  - On source accept: buffer loads data (byte-swapped if SWAP_ENDIAN) and the current address.
  - Address then advances by BW_DATA/8, wrapping modulo 2^BW_ADDR.
  - mem_wvalid = buf_valid; mem_wvalid/waddr/wdata stay stable while wready=0.
  - Simultaneous mem accept and src accept: the buffer is refilled in the same cycle.
  - Latency: accepted word appears on mem_w* the next cycle.
  - word_count counts source accepts per region and resets at region change. progress_pulse fires on the accepting cycle that matches the mask.
  - After the last word of a region is accepted: region_index and address switch to the next non-empty region. After the last region, go to DRAIN.
- DRAIN: src_ready=0; wait until the buffer is empty, then go to SETENV.
- SETENV: one cycle, then DONE.
- DONE: app_ready=1 and busy=0; absorbing until rst.
- Width rule: base + n*BW_DATA/8 is truncated to BW_ADDR bits.

Decomposition:
- Shared package ervp_app_load_pkg holds:
  - boot mode constants (BOOT_MODE_STAND_ALONE=0, BOOT_MODE_OCD=1, BW_BOOT_MODE=2)
  - FSM state encoding
  - byte-swap function
- One sub-module: ervp_app_load_skid, the one-entry valid/ready buffer with endian swap.

Test Plan:
- Stand-alone: rst pulse, boot_mode=0, SETTLE_CYCLES=300 -> subsys_release=1 and app_ready=1 exactly 301 cycles after rst falls; no mem_wvalid ever.
- OCD, 2 regions: bases 0x0000_0000 and 0x8000_0000, sizes 4 and 3, src data 1..7, mem_wready=1 -> writes to 0x0,0x4,0x8,0xC, then 0x8000_0000,0x8000_0004,0x8000_0008; app_ready asserted after the 7th write.
- Backpressure: mem_wready toggles 0/1 every cycle with src always valid -> no data lost or duplicated; mem_w* stable while wready=0; src_ready low whenever the buffer is full and wready=0.
- SWAP_ENDIAN=1: src 0x1234_5678 -> mem_wdata 0x7856_3412. Region size 0 at index 0 -> region_index jumps directly to 1.
- Illegal boot_mode=3 -> error=1, subsys_release=0, app_ready=0; a later rst clears error. rst asserted mid-LOAD after 2 words -> all outputs 0 and the sequence restarts from SETTLE.
- Progress: region size 512, PROGRESS_MASK=255 -> exactly 2 progress_pulse (at words 256 and 512). Base 0xFFFF_FFFC with size 2 -> second write at address 0x0000_0000.
